// File: rtl/request_unit_p_pkg.sv
// Shared CPU types for the request unit.
// Contents:
//   state_t     - request FSM state (FETCH, DATA, HALTED)
//   DEF_TIMEOUT - default wait-cycle limit per memory request
//   DEF_CNT_W   - default width of the stall and wait counters
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/request_unit_p_if.sv
// Bus between the request unit and the fetch/decode/memory side.
// Signals:
//   ihit, dhit        - instruction / data memory completion strobes
//   memread, memwrite - decoded load/store of the fetched instruction
//   halt              - decoded halt of the fetched instruction
//   iREN, dREN, dWEN  - memory read/write enables
//   pcenable          - single-cycle PC advance strobe
//   stall_cnt         - saturating count of stalled cycles
//   timeout           - sticky expired-request flag
// Modports: master drives the hit/decode inputs, slave is the request unit.
interface request_unit_p_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             memread;
  logic             memwrite;
  logic             halt;
  logic             iREN;
  logic             dREN;
  logic             dWEN;
  logic             pcenable;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout;

  modport master (
    output ihit, dhit, memread, memwrite, halt,
    input  iREN, dREN, dWEN, pcenable, stall_cnt, timeout
  );

  modport slave (
    input  ihit, dhit, memread, memwrite, halt,
    output iREN, dREN, dWEN, pcenable, stall_cnt, timeout
  );
endinterface

// File: rtl/request_unit_p_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   clear - synchronous clear (highest priority)
//   inc   - increment enable
//   count - current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/request_unit_p.sv
// Request unit: sequences instruction fetch and the optional data access
// of each instruction, strobes pcenable once per retired instruction,
// counts stalled cycles and halts with a sticky timeout if memory does
// not answer within TIMEOUT cycles.
// Ports:
//   CLK - clock, rising edge
//   RST - synchronous active-high reset
//   bus - request_unit_p_if.slave (hit/decode inputs, enables, status)
module request_unit_p
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic               CLK,
  input logic               RST,
  request_unit_p_if.slave   bus
);

  localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_rd;
  logic             r_wr;
  logic [CNT_W-1:0] r_wait;
  logic             r_timeout;

  logic             w_fetch;
  logic             w_data;
  logic             w_memop;
  logic             w_pcenable;
  logic             w_wait_last;
  logic             w_stall_inc;
  logic [CNT_W-1:0] w_stall_cnt;

  assign w_fetch     = (r_state == FETCH);
  assign w_data      = (r_state == DATA);
  assign w_memop     = bus.memread | bus.memwrite;
  assign w_wait_last = (r_wait == LP_WAIT_LAST);

  // Plain instructions retire on ihit; load/store retire on dhit.
  assign w_pcenable = (w_fetch && bus.ihit && !bus.halt && !w_memop) ||
                      (w_data && bus.dhit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= FETCH;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.ihit) begin
            r_wait <= '0;
            if (bus.halt) begin
              r_state <= HALTED;
            end else if (w_memop) begin
              r_state <= DATA;
              // A load wins over a store when both are decoded.
              r_rd    <= bus.memread;
              r_wr    <= bus.memwrite & ~bus.memread;
            end
          end else if (w_wait_last) begin
            r_timeout <= 1'b1;
            r_state   <= HALTED;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        DATA: begin
          if (bus.dhit) begin
            r_state <= FETCH;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wait  <= '0;
          end else if (w_wait_last) begin
            r_timeout <= 1'b1;
            r_state   <= HALTED;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= HALTED;
        end
      endcase
    end
  end

  assign w_stall_inc = (w_fetch || w_data) && !w_pcenable;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .clear (RST),
    .inc   (w_stall_inc),
    .count (w_stall_cnt)
  );

  assign bus.iREN      = w_fetch;
  assign bus.dREN      = r_rd;
  assign bus.dWEN      = r_wr;
  assign bus.pcenable  = w_pcenable;
  assign bus.stall_cnt = w_stall_cnt;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_request_unit_p.sv
module tb_request_unit_p;

  logic clk;
  logic rst0, rst1, rst2;

  request_unit_p_if #(.CNT_W(16)) if0 ();
  request_unit_p_if #(.CNT_W(16)) if1 ();
  request_unit_p_if #(.CNT_W(3))  if2 ();

  request_unit_p #(.TIMEOUT(64), .CNT_W(16)) dut0 (.CLK(clk), .RST(rst0), .bus(if0));
  request_unit_p #(.TIMEOUT(4),  .CNT_W(16)) dut1 (.CLK(clk), .RST(rst1), .bus(if1));
  request_unit_p #(.TIMEOUT(7),  .CNT_W(3))  dut2 (.CLK(clk), .RST(rst2), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned d;
    string       name;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic        pce;
    int unsigned stall;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [4:0]  a;
    logic [4:0]  w;
    int unsigned as;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.d)
        0: begin a = {if0.iREN, if0.dREN, if0.dWEN, if0.pcenable, if0.timeout}; as = 32'(if0.stall_cnt); end
        1: begin a = {if1.iREN, if1.dREN, if1.dWEN, if1.pcenable, if1.timeout}; as = 32'(if1.stall_cnt); end
        default: begin a = {if2.iREN, if2.dREN, if2.dWEN, if2.pcenable, if2.timeout}; as = 32'(if2.stall_cnt); end
      endcase
      w = {e.iren, e.dren, e.dwen, e.pce, e.to};
      total++;
      if ((a !== w) || (as != e.stall)) begin
        bad++;
        $display("FAIL dut%0d %s: got iren/dren/dwen/pce/to=%b stall=%0d, want %b stall=%0d",
                 e.d, e.name, a, as, w, e.stall);
      end
    end
  end

  task automatic drive(input int unsigned d, input logic rs, ih, dh, mr, mw, hl);
    case (d)
      0: begin rst0 = rs; if0.ihit = ih; if0.dhit = dh; if0.memread = mr; if0.memwrite = mw; if0.halt = hl; end
      1: begin rst1 = rs; if1.ihit = ih; if1.dhit = dh; if1.memread = mr; if1.memwrite = mw; if1.halt = hl; end
      default: begin rst2 = rs; if2.ihit = ih; if2.dhit = dh; if2.memread = mr; if2.memwrite = mw; if2.halt = hl; end
    endcase
  endtask

  // One clock: drive inputs just after the edge, push the expected outputs.
  task automatic step(input int unsigned d, input string nm,
                      input logic rs, ih, dh, mr, mw, hl,
                      input logic ei, edr, edw, ep,
                      input int unsigned es, input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    drive(d, rs, ih, dh, mr, mw, hl);
    e.d = d; e.name = nm; e.iren = ei; e.dren = edr; e.dwen = edw;
    e.pce = ep; e.stall = es; e.to = eto;
    sb.push_back(e);
  endtask

  initial begin
    int unsigned guard;
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(2, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // ---- dut0: default parameters ----
    //          name               rs ih dh mr mw hl  ir dr dw pe st to
    step(0, "rst_state",          1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, "plain_fetch",      0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    step(0, "ld_ihit",            0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    step(0, "ld_wait1",           0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0);
    step(0, "ld_wait2_ihit_ign",  0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
    step(0, "ld_dhit",            0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 3, 0);
    step(0, "fetch_dhit_ign",     0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 3, 0);
    step(0, "both_ihit",          0, 1, 0, 1, 1, 0,  1, 0, 0, 0, 4, 0);
    step(0, "both_wait",          0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 5, 0);
    step(0, "both_dhit",          0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 6, 0);
    step(0, "st_ihit",            0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 6, 0);
    step(0, "st_dhit",            0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 7, 0);
    step(0, "halt_ihit",          0, 1, 0, 0, 1, 1,  1, 0, 0, 0, 7, 0);
    step(0, "halted1",            0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 8, 0);
    step(0, "halted2",            0, 1, 1, 1, 1, 0,  0, 0, 0, 0, 8, 0);
    step(0, "halt_rst",           1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 8, 0);
    step(0, "post_halt_rst",      0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    step(0, "abort_ihit",         0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0);
    step(0, "abort_wait",         0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 2, 0);
    step(0, "abort_rst",          1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 3, 0);
    step(0, "post_abort",         0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    step(0, "park0",              1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);

    // ---- dut1: TIMEOUT=4 ----
    for (int unsigned i = 0; i < 4; i++)
      step(1, "to_idle",          0, 0, 0, 0, 0, 0,  1, 0, 0, 0, i, 0);
    step(1, "to_halted1",         0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 1);
    step(1, "to_halted2",         0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4, 1);
    step(1, "to_rst",             1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 1);
    for (int unsigned i = 0; i < 3; i++)
      step(1, "r2_idle",          0, 0, 0, 0, 0, 0,  1, 0, 0, 0, i, 0);
    step(1, "r2_hit_at_last",     0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 3, 0);
    step(1, "r2_no_timeout",      0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0);
    step(1, "dto_ihit",           0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 4, 0);
    for (int unsigned i = 0; i < 4; i++)
      step(1, "dto_wait",         0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 5 + i, 0);
    step(1, "dto_halted",         0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 9, 1);
    step(1, "park1",              1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 9, 1);

    // ---- dut2: CNT_W=3, TIMEOUT=7 ----
    for (int unsigned i = 0; i < 7; i++)
      step(2, "sat_idle",         0, 0, 0, 0, 0, 0,  1, 0, 0, 0, i, 0);
    step(2, "sat_halted",         0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 7, 1);
    step(2, "sat_rst",            1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 7, 1);
    step(2, "s_ihit",             0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0);
    for (int unsigned i = 1; i <= 5; i++)
      step(2, "s_wait",           0, 0, 0, 0, 0, 0,  0, 1, 0, 0, i, 0);
    step(2, "s_dhit",             0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 6, 0);
    step(2, "s2_ihit",            0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 6, 0);
    for (int i = 0; i < 3; i++)
      step(2, "s2_saturated",     0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 7, 0);
    step(2, "park2",              1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 7, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
